// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter and command sequencer in front of the single-port
// SPI-side RAM. Each granted transaction becomes two RAM command beats
// ({cmd, addr} then {cmd, data}). A read then waits for the RAM data strobe,
// bounded by a timeout. All outputs come straight from registers.
`timescale 1ns/1ps

module ram_cmd_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        op,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*ADDR_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        rvalid,
  output logic [NREQ-1:0]        err,
  output logic [ADDR_W-1:0]      rdata,
  output logic [ADDR_W+1:0]      ram_din,
  output logic                   ram_rx_valid,
  input  logic [ADDR_W-1:0]      ram_dout,
  input  logic                   ram_tx_valid
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  // RAM command codes carried in the top two bits of each beat
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ADDR    = 2'd1,
    ST_DATA    = 2'd2,
    ST_WAIT_RD = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_reg, rr_next;
  logic [IDX_W-1:0]   cur_idx_reg, cur_idx_next;
  logic               cur_op_reg, cur_op_next;
  logic [ADDR_W-1:0]  cur_wdata_reg, cur_wdata_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NREQ-1:0]    gnt_reg, gnt_next;
  logic [NREQ-1:0]    done_reg, done_next;
  logic [NREQ-1:0]    rvalid_reg, rvalid_next;
  logic [NREQ-1:0]    err_reg, err_next;
  logic [ADDR_W-1:0]  rdata_reg, rdata_next;
  logic [ADDR_W+1:0]  ram_din_reg, ram_din_next;
  logic               ram_rx_valid_reg, ram_rx_valid_next;

  // Per-requester views of the packed buses and the rotated request vector:
  // slot gi of req_rot is the requester gi+1 positions after the last winner.
  logic [ADDR_W-1:0]  addr_arr  [NREQ];
  logic [ADDR_W-1:0]  wdata_arr [NREQ];
  logic [SUM_W-1:0]   cand_sum  [NREQ];
  logic [IDX_W-1:0]   cand_idx  [NREQ];
  logic [NREQ-1:0]    req_rot;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [ADDR_W-1:0]  data_payload;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata[gi*ADDR_W +: ADDR_W];
      // (rr + 1 + gi) mod NREQ without a divider: sum is below 2*NREQ
      assign cand_sum[gi]  = {1'b0, rr_reg} + SUM_W'(gi + 1);
      assign cand_idx[gi]  = (cand_sum[gi] >= SUM_W'(NREQ))
                             ? IDX_W'(cand_sum[gi] - SUM_W'(NREQ))
                             : IDX_W'(cand_sum[gi]);
      assign req_rot[gi]   = req[cand_idx[gi]];
    end
  endgenerate

  function automatic logic [NREQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Pick the first pending requester after the previous winner (with wrap)
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  // Second beat carries write data, or zeros for a read
  assign data_payload = cur_op_reg ? {ADDR_W{1'b0}} : cur_wdata_reg;

  // Next-state and next-output logic; pulses default low every cycle
  always_comb begin
    state_next        = state_reg;
    rr_next           = rr_reg;
    cur_idx_next      = cur_idx_reg;
    cur_op_next       = cur_op_reg;
    cur_wdata_next    = cur_wdata_reg;
    cnt_next          = cnt_reg;
    gnt_next          = '0;
    done_next         = '0;
    rvalid_next       = '0;
    err_next          = '0;
    rdata_next        = rdata_reg;
    ram_din_next      = '0;
    ram_rx_valid_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (win_found) begin
          cur_idx_next      = win_idx;
          cur_op_next       = op[win_idx];
          cur_wdata_next    = wdata_arr[win_idx];
          rr_next           = win_idx;
          gnt_next          = idx_onehot(win_idx);
          ram_rx_valid_next = 1'b1;
          ram_din_next      = {op[win_idx] ? CMD_RD_ADDR : CMD_WR_ADDR, addr_arr[win_idx]};
          state_next        = ST_ADDR;
        end
      end

      ST_ADDR: begin
        ram_rx_valid_next = 1'b1;
        ram_din_next      = {cur_op_reg ? CMD_RD_DATA : CMD_WR_DATA, data_payload};
        state_next        = ST_DATA;
      end

      ST_DATA: begin
        if (cur_op_reg) begin
          cnt_next   = '0;
          state_next = ST_WAIT_RD;
        end else begin
          done_next  = idx_onehot(cur_idx_reg);
          state_next = ST_IDLE;
        end
      end

      ST_WAIT_RD: begin
        if (ram_tx_valid) begin
          rdata_next  = ram_dout;
          rvalid_next = idx_onehot(cur_idx_reg);
          state_next  = ST_IDLE;
        end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          err_next   = idx_onehot(cur_idx_reg);
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // State, payload and output registers; reset abandons any transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      rr_reg           <= IDX_W'(NREQ - 1);
      cur_idx_reg      <= '0;
      cur_op_reg       <= 1'b0;
      cur_wdata_reg    <= '0;
      cnt_reg          <= '0;
      gnt_reg          <= '0;
      done_reg         <= '0;
      rvalid_reg       <= '0;
      err_reg          <= '0;
      rdata_reg        <= '0;
      ram_din_reg      <= '0;
      ram_rx_valid_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      rr_reg           <= rr_next;
      cur_idx_reg      <= cur_idx_next;
      cur_op_reg       <= cur_op_next;
      cur_wdata_reg    <= cur_wdata_next;
      cnt_reg          <= cnt_next;
      gnt_reg          <= gnt_next;
      done_reg         <= done_next;
      rvalid_reg       <= rvalid_next;
      err_reg          <= err_next;
      rdata_reg        <= rdata_next;
      ram_din_reg      <= ram_din_next;
      ram_rx_valid_reg <= ram_rx_valid_next;
    end
  end

  assign gnt          = gnt_reg;
  assign done         = done_reg;
  assign rvalid       = rvalid_reg;
  assign err          = err_reg;
  assign rdata        = rdata_reg;
  assign ram_din      = ram_din_reg;
  assign ram_rx_valid = ram_rx_valid_reg;

endmodule
